// File: rtl/pulse_train_generator.sv
// Programmable pulse train: a START strobe produces NUM_PULSES active pulses of
// HIGH_TIME cycles separated by LOW_TIME cycles, or runs continuously when NUM_PULSES=0.
//   state | meaning
//   IDLE  | waiting for START, SIGNAL inactive
//   HIGH  | active phase of the current pulse
//   LOW   | inactive gap between pulses
module pulse_train_generator #(
    parameter int   CNT_WIDTH    = 16,
    parameter int   NUM_WIDTH    = 8,
    parameter logic ACTIVE_LEVEL = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 ENABLE,
    input  logic                 START,
    input  logic                 STOP,
    input  logic [CNT_WIDTH-1:0] HIGH_TIME,
    input  logic [CNT_WIDTH-1:0] LOW_TIME,
    input  logic [NUM_WIDTH-1:0] NUM_PULSES,
    output logic                 SIGNAL,
    output logic                 BUSY,
    output logic                 DONE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] phase_cnt;
    logic [NUM_WIDTH-1:0] pulse_cnt;
    logic [CNT_WIDTH-1:0] h_lat;
    logic [CNT_WIDTH-1:0] l_lat;
    logic [NUM_WIDTH-1:0] n_lat;

    // zero-length phases are stretched to one cycle
    logic [CNT_WIDTH-1:0] h_eff;
    logic [CNT_WIDTH-1:0] l_eff;
    assign h_eff = (HIGH_TIME == '0) ? CNT_WIDTH'(1) : HIGH_TIME;
    assign l_eff = (LOW_TIME  == '0) ? CNT_WIDTH'(1) : LOW_TIME;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            phase_cnt <= '0;
            pulse_cnt <= '0;
            h_lat     <= '0;
            l_lat     <= '0;
            n_lat     <= '0;
            SIGNAL    <= ~ACTIVE_LEVEL;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (ENABLE && START && !STOP) begin
                        h_lat     <= h_eff;
                        l_lat     <= l_eff;
                        n_lat     <= NUM_PULSES;
                        phase_cnt <= h_eff - CNT_WIDTH'(1);
                        pulse_cnt <= NUM_WIDTH'(1);
                        state     <= HIGH;
                        SIGNAL    <= ACTIVE_LEVEL;
                        BUSY      <= 1'b1;
                    end
                end
                HIGH, LOW: begin
                    if (STOP || !ENABLE) begin
                        state     <= IDLE;
                        phase_cnt <= '0;
                        pulse_cnt <= '0;
                        SIGNAL    <= ~ACTIVE_LEVEL;
                        BUSY      <= 1'b0;
                    end else if (phase_cnt != '0) begin
                        phase_cnt <= phase_cnt - CNT_WIDTH'(1);
                    end else if (state == HIGH) begin
                        SIGNAL <= ~ACTIVE_LEVEL;
                        if (n_lat != '0 && pulse_cnt == n_lat) begin
                            // last pulse ends the train with no trailing gap
                            state     <= IDLE;
                            pulse_cnt <= '0;
                            BUSY      <= 1'b0;
                            DONE      <= 1'b1;
                        end else begin
                            state     <= LOW;
                            phase_cnt <= l_lat - CNT_WIDTH'(1);
                        end
                    end else begin
                        state     <= HIGH;
                        phase_cnt <= h_lat - CNT_WIDTH'(1);
                        SIGNAL    <= ACTIVE_LEVEL;
                        if (pulse_cnt != '1)
                            pulse_cnt <= pulse_cnt + NUM_WIDTH'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    SIGNAL <= ~ACTIVE_LEVEL;
                    BUSY   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed and randomized bench for pulse_train_generator; an active-low copy
// runs in parallel on the same stimulus and must always show the inverted waveform.
module tb_pulse_train_generator;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        ENABLE = 1'b0;
    logic        START = 1'b0;
    logic        STOP = 1'b0;
    logic [15:0] HIGH_TIME = '0;
    logic [15:0] LOW_TIME = '0;
    logic [7:0]  NUM_PULSES = '0;
    logic        sig_p, busy_p, done_p;
    logic        sig_n, busy_n, done_n;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    pulse_train_generator #(.CNT_WIDTH(16), .NUM_WIDTH(8), .ACTIVE_LEVEL(1'b1)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .START(START), .STOP(STOP),
        .HIGH_TIME(HIGH_TIME), .LOW_TIME(LOW_TIME), .NUM_PULSES(NUM_PULSES),
        .SIGNAL(sig_p), .BUSY(busy_p), .DONE(done_p)
    );

    pulse_train_generator #(.CNT_WIDTH(16), .NUM_WIDTH(8), .ACTIVE_LEVEL(1'b0)) dut_n (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .START(START), .STOP(STOP),
        .HIGH_TIME(HIGH_TIME), .LOW_TIME(LOW_TIME), .NUM_PULSES(NUM_PULSES),
        .SIGNAL(sig_n), .BUSY(busy_n), .DONE(done_n)
    );

    // advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic s, input logic b, input logic d);
        n_assert++;
        assert (sig_p === s) else begin
            n_fail++; $error("FAIL %s SIGNAL observed %b expected %b", tag, sig_p, s);
        end
        n_assert++;
        assert (busy_p === b) else begin
            n_fail++; $error("FAIL %s BUSY observed %b expected %b", tag, busy_p, b);
        end
        n_assert++;
        assert (done_p === d) else begin
            n_fail++; $error("FAIL %s DONE observed %b expected %b", tag, done_p, d);
        end
        n_assert++;
        assert ({sig_n, busy_n, done_n} === {~s, b, d}) else begin
            n_fail++; $error("FAIL %s active-low copy observed %b%b%b expected %b%b%b",
                             tag, sig_n, busy_n, done_n, ~s, b, d);
        end
    endtask

    // Finite train: expected waveform built as a list of active/inactive cycles.
    // disturb re-pulses START and changes the inputs mid-train.
    task automatic run_train(input string tag, input int h, input int l, input int n,
                             input bit disturb);
        bit exp_q[$];
        int hh = (h == 0) ? 1 : h;
        int ll = (l == 0) ? 1 : l;
        for (int p = 1; p <= n; p++) begin
            repeat (hh) exp_q.push_back(1'b1);
            if (p < n) repeat (ll) exp_q.push_back(1'b0);
        end
        HIGH_TIME  = 16'(h);
        LOW_TIME   = 16'(l);
        NUM_PULSES = 8'(n);
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            check(tag, exp_q[i], 1'b1, 1'b0);
            if (disturb && i == 1) begin
                START = 1'b1;
                HIGH_TIME  = 16'd9;
                LOW_TIME   = 16'd7;
                NUM_PULSES = 8'd5;
            end else begin
                START = 1'b0;
            end
            tick();
        end
        START = 1'b0;
        check({tag, "_done"}, 1'b0, 1'b0, 1'b1);
    endtask

    // Continuous train for `cycles` cycles, then aborted by STOP or ENABLE low.
    task automatic run_cont(input string tag, input int h, input int l, input int cycles,
                            input bit use_stop);
        int hh = (h == 0) ? 1 : h;
        int ll = (l == 0) ? 1 : l;
        HIGH_TIME  = 16'(h);
        LOW_TIME   = 16'(l);
        NUM_PULSES = 8'd0;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            check(tag, ((i % (hh + ll)) < hh), 1'b1, 1'b0);
            tick();
        end
        if (use_stop) STOP = 1'b1; else ENABLE = 1'b0;
        tick();
        STOP = 1'b0;
        check({tag, "_abort"}, 1'b0, 1'b0, 1'b0);
        ENABLE = 1'b1;
        tick();
        check({tag, "_idle"}, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #12;
        check("reset", 1'b0, 1'b0, 1'b0);
        RESET = 1'b1;
        ENABLE = 1'b1;
        tick();
        check("post_reset", 1'b0, 1'b0, 1'b0);

        run_train("h3l2n2", 3, 2, 2, 1'b0);
        tick();
        check("after_done", 1'b0, 1'b0, 1'b0);

        run_train("h0l0n1", 0, 0, 1, 1'b0);
        // START on the DONE cycle is accepted
        run_train("back_to_back", 2, 1, 2, 1'b0);
        tick();

        run_cont("toggle", 1, 1, 20, 1'b1);

        run_train("latched_inputs", 4, 4, 3, 1'b1);
        tick();

        ENABLE = 1'b0;
        START = 1'b1;
        HIGH_TIME = 16'd3;
        NUM_PULSES = 8'd1;
        repeat (3) begin
            tick();
            check("disabled_start", 1'b0, 1'b0, 1'b0);
        end
        ENABLE = 1'b1;
        STOP = 1'b1;
        repeat (3) begin
            tick();
            check("start_and_stop", 1'b0, 1'b0, 1'b0);
        end
        START = 1'b0;
        STOP = 1'b0;
        tick();

        // async reset mid-pulse, checked between clock edges
        HIGH_TIME = 16'd6;
        LOW_TIME = 16'd2;
        NUM_PULSES = 8'd2;
        START = 1'b1;
        tick();
        START = 1'b0;
        check("pre_reset_high", 1'b1, 1'b1, 1'b0);
        tick();
        #1 RESET = 1'b0;
        #1;
        check("async_reset", 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        RESET = 1'b1;
        tick();
        check("reset_release", 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 10; k++) begin
            run_train("rand_train", int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                      int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) tick();
        end
        for (int k = 0; k < 4; k++) begin
            run_cont("rand_cont", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(5, 25)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_train_generator.md
Name: pulse_train_generator

Overview:
Generates programmable pulse trains on a single-bit output. It is the transmit-side counterpart of the edge-detection logic: edge detection turns level transitions into one-cycle strobes, and this block turns a one-cycle START strobe into a timed sequence of rising and falling edges. Typical uses are driving strobes and chip-selects and stimulating edge-detection paths. It sits in the RTL library beside the other small control/timing primitives.

Parameters:
CNT_WIDTH, 16, width of HIGH_TIME/LOW_TIME and the internal phase counter
NUM_WIDTH, 8, width of NUM_PULSES and the internal pulse counter
ACTIVE_LEVEL, 1'b1, level of SIGNAL during the high phase; SIGNAL idles at ~ACTIVE_LEVEL

Ports:
CLK  input  1  system clock, all logic on rising edge
RESET  input  1  asynchronous, active-low reset
ENABLE  input  1  block enable; low forces idle and START is ignored
START  input  1  one-cycle strobe; begins a train when idle
STOP  input  1  one-cycle strobe; aborts an active train
HIGH_TIME  input  CNT_WIDTH  active-phase length in cycles (0 treated as 1)
LOW_TIME  input  CNT_WIDTH  inactive-phase length between pulses in cycles (0 treated as 1)
NUM_PULSES  input  NUM_WIDTH  pulses per train; 0 = continuous until STOP
SIGNAL  output  1  generated waveform (registered)
BUSY  output  1  high while a train is in progress (registered)
DONE  output  1  one-cycle strobe when a finite train completes normally (registered)

Behaviour:
- Reset (RESET=0, async): state=IDLE, SIGNAL=~ACTIVE_LEVEL, BUSY=0, DONE=0, all counters cleared. Takes effect immediately, including mid-train.
- States: IDLE, HIGH, LOW. All outputs are registered, with no combinational path from inputs.
- IDLE: on the edge where START=1, ENABLE=1 and STOP=0:
  - Latch H=max(HIGH_TIME,1), L=max(LOW_TIME,1) and N=NUM_PULSES.
  - Go to HIGH. SIGNAL=ACTIVE_LEVEL and BUSY=1 on that same edge, so latency from START is 1 cycle.
- HIGH: SIGNAL stays active for exactly H cycles. At the end of the phase:
  - If N!=0 and this was pulse N: go to IDLE, SIGNAL=~ACTIVE_LEVEL, BUSY=0, DONE=1 for one cycle. There is no trailing low phase.
  - Otherwise: go to LOW, SIGNAL=~ACTIVE_LEVEL.
- LOW: inactive for exactly L cycles, then back to HIGH. The pulse count increments on each HIGH entry.
- Finite train BUSY length = N*H + (N-1)*L cycles.
- Continuous mode (N=0): alternates HIGH/LOW indefinitely. DONE never asserts.
- Abort: STOP=1 or ENABLE=0 in HIGH or LOW gives IDLE on the next edge, SIGNAL=~ACTIVE_LEVEL, BUSY=0, DONE=0.
- START while BUSY=1: ignored. Input changes while busy have no effect, because the values were latched at start.
- START and STOP in the same cycle in IDLE: STOP wins and nothing starts.
- START on the same cycle DONE asserts (block already in IDLE): accepted normally.
- Counters: no wrap-around. The phase counter loads H-1 or L-1 and counts down to 0. The pulse counter saturates at its maximum in continuous mode.

Test Plan:
1. H=3, L=2, N=2, ACTIVE_LEVEL=1, START at t0:
   - SIGNAL sequence 1,1,1,0,0,1,1,1 starting at t0+1.
   - BUSY high for 8 cycles.
   - DONE=1 at t0+9 only, with SIGNAL=0 and BUSY=0 at that cycle.
2. HIGH_TIME=0, LOW_TIME=0, N=1: SIGNAL high for exactly 1 cycle, then DONE=1 the following cycle.
3. H=1, L=1, N=0: SIGNAL toggles every cycle for 20 cycles.
   - STOP then drives SIGNAL=0 and BUSY=0 on the next edge.
   - DONE stays 0 throughout.
4. H=4, L=4, N=3:
   - Pulse START again and change HIGH_TIME to 9 mid-train.
   - Train is unchanged: 3 pulses of 4 cycles, total BUSY=20 cycles.
5. ENABLE=0 with START: no activity, SIGNAL=0, BUSY=0.
   - Separately, assert RESET low during HIGH: SIGNAL=0 and BUSY=0 immediately, without waiting for a clock edge.
6. START and STOP asserted together in IDLE: BUSY stays 0 and SIGNAL never toggles.
   - With ACTIVE_LEVEL=0 and a normal train, SIGNAL idles at 1 and pulses to 0.
